// File: rtl/icache_if.sv
// Fetch-side and memory-side signal bundle for the instruction cache.
// slave is the cache's view; master is the combined pipeline/memory view.
interface icache_if;
  logic        dp_imemREN;
  logic [31:0] dp_imemaddr;
  logic        dp_ihit;
  logic [31:0] dp_imemload;
  logic        ram_iREN;
  logic [31:0] ram_iaddr;
  logic        ram_iwait;
  logic [31:0] ram_iload;

  modport slave (
    input  dp_imemREN, dp_imemaddr, ram_iwait, ram_iload,
    output dp_ihit, dp_imemload, ram_iREN, ram_iaddr
  );

  modport master (
    output dp_imemREN, dp_imemaddr, ram_iwait, ram_iload,
    input  dp_ihit, dp_imemload, ram_iREN, ram_iaddr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between fetch and memory.
// Hits are combinational; a miss fetches the word through a COMPARE/FETCH FSM.
module icache #(
  parameter int unsigned SETS = 16
) (
  input logic     CLK,
  input logic     RST,
  icache_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 30 - IDX_W;

  typedef enum logic {COMPARE, FETCH} state_t;

  state_t            r_state, w_next;
  logic [SETS-1:0]   r_valid;
  logic [TAG_W-1:0]  r_tag  [SETS];
  logic [31:0]       r_data [SETS];
  logic [31:0]       r_miss_addr;

  logic [IDX_W-1:0]  w_idx, w_fill_idx;
  logic [TAG_W-1:0]  w_tag, w_fill_tag;
  logic              w_hit, w_latch, w_fill;
  logic              w_ihit, w_iren;
  logic [31:0]       w_imemload, w_iaddr;

  assign w_idx      = bus.dp_imemaddr[IDX_W+1:2];
  assign w_tag      = bus.dp_imemaddr[31:IDX_W+2];
  assign w_fill_idx = r_miss_addr[IDX_W+1:2];
  assign w_fill_tag = r_miss_addr[31:IDX_W+2];

  always_comb begin
    w_next     = r_state;
    w_hit      = 1'b0;
    w_latch    = 1'b0;
    w_fill     = 1'b0;
    w_ihit     = 1'b0;
    w_imemload = '0;
    w_iren     = 1'b0;
    w_iaddr    = '0;
    case (r_state)
      COMPARE: begin
        w_hit      = bus.dp_imemREN & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
        w_ihit     = w_hit;
        w_imemload = w_hit ? r_data[w_idx] : '0;
        if (bus.dp_imemREN && !w_hit) begin
          w_latch = 1'b1;
          w_next  = FETCH;
        end
      end
      FETCH: begin
        // Dropping REN aborts the fill and releases the memory request at once.
        w_iren  = bus.dp_imemREN;
        w_iaddr = r_miss_addr;
        if (!bus.dp_imemREN) begin
          w_next = COMPARE;
        end else if (!bus.ram_iwait) begin
          w_fill = 1'b1;
          w_next = COMPARE;
        end
      end
      default: w_next = COMPARE;
    endcase
  end

  assign bus.dp_ihit     = w_ihit;
  assign bus.dp_imemload = w_imemload;
  assign bus.ram_iREN    = w_iren;
  assign bus.ram_iaddr   = w_iaddr;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= COMPARE;
      r_valid     <= '0;
      r_miss_addr <= '0;
    end else begin
      r_state <= w_next;
      if (w_latch) r_miss_addr <= bus.dp_imemaddr & ~32'd3;
      if (w_fill)  r_valid[w_fill_idx] <= 1'b1;
    end
  end

  // Tag/data need no reset: they are only observed behind a set valid bit.
  always_ff @(posedge CLK) begin
    if (!RST && w_fill) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= bus.ram_iload;
    end
  end
endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus randomized accesses
// checked against an address-level model of the cache contents.
module tb_icache;
  localparam int unsigned SETS = 16;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  icache_if bus ();

  icache #(.SETS(SETS)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Model: which word address each line holds, and the memory image.
  bit          m_valid [SETS];
  logic [31:0] m_waddr [SETS];
  logic [31:0] m_data  [SETS];
  logic [31:0] mem [logic [31:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] memrd(input logic [31:0] wa);
    if (!mem.exists(wa)) mem[wa] = $urandom;
    return mem[wa];
  endfunction

  function automatic int unsigned line_of(input logic [31:0] a);
    return (a / 4) % SETS;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.dp_imemREN  = 1'b0;
    bus.dp_imemaddr = $urandom;
    bus.ram_iwait   = $urandom_range(0, 1);
    bus.ram_iload   = $urandom;
    @(negedge CLK);
    chk("idle_ihit", {31'd0, bus.dp_ihit}, 32'd0);
    chk("idle_load", bus.dp_imemload, 32'd0);
    chk("idle_iREN", {31'd0, bus.ram_iREN}, 32'd0);
    chk("idle_iaddr", bus.ram_iaddr, 32'd0);
    tick();
  endtask

  // Full request: hit in one cycle, or miss + (waits+1) fetch cycles + hit.
  task automatic access(input logic [31:0] a, input int unsigned waits,
                        input bit wander, output bit missed);
    int unsigned li = line_of(a);
    logic [31:0] wa = a & ~32'd3;
    bit exp_hit = m_valid[li] && (m_waddr[li] == wa);
    bus.dp_imemREN  = 1'b1;
    bus.dp_imemaddr = a;
    bus.ram_iwait   = 1'b0;
    bus.ram_iload   = $urandom;
    @(negedge CLK);
    missed = ~bus.dp_ihit;
    chk("cmp_ihit", {31'd0, bus.dp_ihit}, {31'd0, exp_hit});
    chk("cmp_iREN", {31'd0, bus.ram_iREN}, 32'd0);
    chk("cmp_load", bus.dp_imemload, exp_hit ? m_data[li] : 32'd0);
    tick();
    if (exp_hit) return;
    for (int k = 0; k <= int'(waits); k++) begin
      bus.ram_iwait = (k < int'(waits));
      bus.ram_iload = (k < int'(waits)) ? $urandom : memrd(wa);
      if (wander) bus.dp_imemaddr = $urandom;
      @(negedge CLK);
      chk("fetch_iREN", {31'd0, bus.ram_iREN}, 32'd1);
      chk("fetch_iaddr", bus.ram_iaddr, wa);
      chk("fetch_ihit", {31'd0, bus.dp_ihit}, 32'd0);
      chk("fetch_load", bus.dp_imemload, 32'd0);
      tick();
    end
    m_valid[li] = 1'b1;
    m_waddr[li] = wa;
    m_data[li]  = mem[wa];
    bus.dp_imemaddr = a;
    bus.ram_iwait   = 1'b0;
    @(negedge CLK);
    chk("fill_ihit", {31'd0, bus.dp_ihit}, 32'd1);
    chk("fill_load", bus.dp_imemload, m_data[li]);
    chk("fill_iREN", {31'd0, bus.ram_iREN}, 32'd0);
    tick();
  endtask

  // Miss, spend `stall` wait cycles in FETCH, then drop REN to abort.
  task automatic halt_fetch(input logic [31:0] a, input int unsigned stall);
    int unsigned li = line_of(a);
    bit exp_hit = m_valid[li] && (m_waddr[li] == (a & ~32'd3));
    bus.dp_imemREN  = 1'b1;
    bus.dp_imemaddr = a;
    bus.ram_iwait   = 1'b1;
    @(negedge CLK);
    chk("halt_miss", {31'd0, bus.dp_ihit}, {31'd0, exp_hit});
    tick();
    if (exp_hit) return;
    for (int k = 0; k < int'(stall); k++) begin
      @(negedge CLK);
      chk("halt_wait_iREN", {31'd0, bus.ram_iREN}, 32'd1);
      tick();
    end
    bus.dp_imemREN = 1'b0;
    bus.ram_iload  = $urandom;
    @(negedge CLK);
    chk("halt_iREN", {31'd0, bus.ram_iREN}, 32'd0);
    chk("halt_ihit", {31'd0, bus.dp_ihit}, 32'd0);
    tick();
    idle();
  endtask

  initial begin
    bit missed;
    logic [31:0] a;
    bus.dp_imemREN  = 1'b0;
    bus.dp_imemaddr = '0;
    bus.ram_iwait   = 1'b0;
    bus.ram_iload   = '0;
    model_clear();

    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    idle();

    // Cold miss then warm hit
    mem[32'h4] = 32'h2002_0001;
    access(32'h0000_0004, 0, 1'b0, missed);
    chk("cold_missed", {31'd0, missed}, 32'd1);
    access(32'h0000_0004, 0, 1'b0, missed);
    chk("warm_missed", {31'd0, missed}, 32'd0);

    // Conflict between 0x00 and 0x40 on line 0
    mem[32'h0]  = 32'hAAAA_AAAA;
    mem[32'h40] = 32'hBBBB_BBBB;
    access(32'h0000_0000, 0, 1'b0, missed);
    access(32'h0000_0040, 1, 1'b0, missed);
    chk("conflict_40_missed", {31'd0, missed}, 32'd1);
    access(32'h0000_0000, 0, 1'b0, missed);
    chk("conflict_00_missed", {31'd0, missed}, 32'd1);

    // Three wait states, address wandering during FETCH
    access(32'h0000_0100, 3, 1'b1, missed);
    chk("wait_missed", {31'd0, missed}, 32'd1);

    // Halt mid-fetch leaves no partial fill
    halt_fetch(32'h0000_0008, 1);
    access(32'h0000_0008, 0, 1'b0, missed);
    chk("halt_refetch_missed", {31'd0, missed}, 32'd1);

    // Reset during FETCH
    bus.dp_imemREN  = 1'b1;
    bus.dp_imemaddr = 32'h0000_0200;
    bus.ram_iwait   = 1'b1;
    tick();
    @(negedge CLK);
    chk("pre_rst_iREN", {31'd0, bus.ram_iREN}, 32'd1);
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    model_clear();
    idle();
    access(32'h0000_0004, 0, 1'b0, missed);
    chk("post_rst_missed", {31'd0, missed}, 32'd1);

    // Randomized mix over a small address pool to get hits and conflicts
    for (int n = 0; n < 300; n++) begin
      a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      case ($urandom_range(0, 9))
        0:       halt_fetch(a, $urandom_range(0, 2));
        1:       idle();
        default: access(a, $urandom_range(0, 3), $urandom_range(0, 1), missed);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
